// File: rtl/rt_cmd_scheduler_pkg.sv
// rt_cmd_pkg: shared types for the real-time command write scheduler.
// Holds the command bundle layout, its width and the write-timer state enum.
package rt_cmd_pkg;

   localparam int CMD_W = 338;

   typedef struct packed {
      logic [47:0] FREQ;
      logic [47:0] FREQ_STEP;
      logic [31:0] FREQ_RATE;
      logic [63:0] TIME_START;
      logic [15:0] N_impuls;
      logic [1:0]  TYPE_impulse;
      logic [31:0] Interval_Ti;
      logic [31:0] Interval_Tp;
      logic [31:0] Tblank1;
      logic [31:0] Tblank2;
   } cmd_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_WRITE = 2'd2,
      ST_GAP   = 2'd3
   } wr_state_t;

   // Returns the base command with its start time replaced.
   function automatic cmd_t cmd_with_time_start(input cmd_t base, input logic [63:0] ts);
      cmd_t c;
      c            = base;
      c.TIME_START = ts;
      return c;
   endfunction

endpackage

// File: rtl/rt_cmd_scheduler_if.sv
// rt_cmd_scheduler_if: MCU one-shot, auto-repeat and wcm write-port signals.
// master = requester/consumer side, slave = the scheduler.
interface rt_cmd_scheduler_if;
   import rt_cmd_pkg::*;

   logic [63:0] TIME;
   logic        SYS_TIME_UPDATE_OK;
   cmd_t        MCU_CMD;
   logic        MCU_WR;
   logic        MCU_BUSY;
   logic        MCU_DROP;
   cmd_t        REP_CMD;
   logic [63:0] REP_PERIOD;
   logic [15:0] REP_COUNT;
   logic        REP_START;
   logic        REP_ABORT;
   logic        REP_ACTIVE;
   logic        REP_DONE;
   logic        ERR_LATE;
   cmd_t        CMD_OUT;
   logic        SPI_WR;

   modport master (
      output TIME, SYS_TIME_UPDATE_OK, MCU_CMD, MCU_WR,
             REP_CMD, REP_PERIOD, REP_COUNT, REP_START, REP_ABORT,
      input  MCU_BUSY, MCU_DROP, REP_ACTIVE, REP_DONE, ERR_LATE, CMD_OUT, SPI_WR
   );

   modport slave (
      input  TIME, SYS_TIME_UPDATE_OK, MCU_CMD, MCU_WR,
             REP_CMD, REP_PERIOD, REP_COUNT, REP_START, REP_ABORT,
      output MCU_BUSY, MCU_DROP, REP_ACTIVE, REP_DONE, ERR_LATE, CMD_OUT, SPI_WR
   );

endinterface

// File: rtl/rt_cmd_scheduler_wr_pulse_gen.sv
// rt_wr_pulse_gen: SETUP / WRITE / GAP timer for the wcm SPI_WR strobe.
// A grant starts one write. busy is low in IDLE and in the final GAP cycle,
// which is where the next grant may be taken so back-to-back writes start
// exactly 1 + WR_PULSE_LEN + WR_GAP cycles apart.
module rt_wr_pulse_gen
   import rt_cmd_pkg::*;
#(
   parameter int unsigned WR_PULSE_LEN = 5,
   parameter int unsigned WR_GAP       = 4
)(
   input  logic clk,
   input  logic rst,
   input  logic i_grant,
   output logic o_busy,
   output logic o_gap_enter,
   output logic o_spi_wr
);

   localparam logic [15:0] PULSE_LAST = 16'(WR_PULSE_LEN - 1);
   localparam logic [15:0] GAP_LAST   = 16'(WR_GAP - 1);

   wr_state_t   r_state;
   logic [15:0] r_cnt;
   logic        r_spi_wr;
   logic        w_cnt_zero;

   assign w_cnt_zero  = (r_cnt == 16'd0);
   assign o_gap_enter = (r_state == ST_WRITE) && w_cnt_zero;
   assign o_busy      = !((r_state == ST_IDLE) || ((r_state == ST_GAP) && w_cnt_zero));
   assign o_spi_wr    = r_spi_wr;

   // Write-cycle state machine with registered SPI_WR.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_cnt    <= 16'd0;
         r_spi_wr <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_grant) begin
                  r_state <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               r_state  <= ST_WRITE;
               r_cnt    <= PULSE_LAST;
               r_spi_wr <= 1'b1;
            end
            ST_WRITE: begin
               if (w_cnt_zero) begin
                  r_state  <= ST_GAP;
                  r_cnt    <= GAP_LAST;
                  r_spi_wr <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - 16'd1;
               end
            end
            ST_GAP: begin
               if (!w_cnt_zero) begin
                  r_cnt <= r_cnt - 16'd1;
               end else if (i_grant) begin
                  r_state <= ST_SETUP;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state  <= ST_IDLE;
               r_cnt    <= 16'd0;
               r_spi_wr <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/rt_cmd_scheduler.sv
// rt_cmd_scheduler: shares the wcm command write port between one-shot MCU
// commands (fixed priority) and an auto-repeat engine that advances
// TIME_START by a fixed period per entry.
// Optional build macro RT_LATE_SKIP_EN: skip repeat entries whose start time
// is not beyond TIME + LEAD and flag them on ERR_LATE.
module rt_cmd_scheduler
   import rt_cmd_pkg::*;
#(
   parameter int unsigned WR_PULSE_LEN = 5,
   parameter int unsigned WR_GAP       = 4,
   parameter int unsigned LEAD         = 64
)(
   input logic               clk,
   input logic               rst,
   rt_cmd_scheduler_if.slave bus
);

   logic        r_mcu_wr_q;
   logic        r_sys_q;
   logic        r_mcu_full;
   cmd_t        r_mcu_buf;
   logic        r_mcu_drop;
   logic        r_rep_active;
   cmd_t        r_rep_base;
   logic [63:0] r_rep_period;
   logic [15:0] r_rep_remaining;
   logic [63:0] r_next_ts;
   logic        r_rep_done;
   logic        r_err_late;
   cmd_t        r_cmd_out;
   logic        r_cur_mcu;
   logic        r_cur_rep;

   logic        w_mcu_edge;
   logic        w_abort;
   logic        w_start;
   logic        w_arb;
   logic        w_mcu_req;
   logic        w_rep_req;
   logic        w_late;
   logic        w_grant_mcu;
   logic        w_grant_rep;
   logic        w_skip;
   logic        w_grant;
   logic        w_done;
   logic        w_pg_busy;
   logic        w_gap_enter;
   logic        w_spi_wr;
   cmd_t        w_mcu_src;
   cmd_t        w_rep_cmd;
   logic [CMD_W-1:0] w_cmd_out_bits;

   assign w_mcu_edge = bus.MCU_WR & ~r_mcu_wr_q;
   assign w_abort    = bus.REP_ABORT | (bus.SYS_TIME_UPDATE_OK & ~r_sys_q);
   assign w_start    = bus.REP_START & ~r_rep_active & ~w_abort;
   assign w_arb      = ~w_pg_busy;
   assign w_mcu_req  = r_mcu_full | w_mcu_edge;
   assign w_rep_req  = r_rep_active & (r_rep_remaining != 16'd0) & ~w_abort;
   assign w_done     = w_arb & r_rep_active & (r_rep_remaining == 16'd0) & ~w_abort;
   assign w_grant    = w_grant_mcu | w_grant_rep;
   assign w_mcu_src  = r_mcu_full ? r_mcu_buf : bus.MCU_CMD;
   assign w_rep_cmd  = cmd_with_time_start(r_rep_base, r_next_ts);

`ifdef RT_LATE_SKIP_EN
   logic [63:0] w_late_limit;
   assign w_late_limit = bus.TIME + 64'(LEAD);
   assign w_late       = (r_next_ts <= w_late_limit);
`else
   logic w_unused_cfg;
   assign w_late       = 1'b0;
   assign w_unused_cfg = ^{bus.TIME, 32'(LEAD)};
`endif

   // Grant at most one write per arbitration slot, MCU before repeat.
   always_comb begin
      w_grant_mcu = 1'b0;
      w_grant_rep = 1'b0;
      w_skip      = 1'b0;
      if (w_arb) begin
         if (w_mcu_req) begin
            w_grant_mcu = 1'b1;
         end else if (w_rep_req) begin
            if (w_late) begin
               w_skip = 1'b1;
            end else begin
               w_grant_rep = 1'b1;
            end
         end else begin
            w_grant_rep = 1'b0;
         end
      end else begin
         w_grant_mcu = 1'b0;
      end
   end

   rt_wr_pulse_gen #(
      .WR_PULSE_LEN (WR_PULSE_LEN),
      .WR_GAP       (WR_GAP)
   ) u_pulse (
      .clk         (clk),
      .rst         (rst),
      .i_grant     (w_grant),
      .o_busy      (w_pg_busy),
      .o_gap_enter (w_gap_enter),
      .o_spi_wr    (w_spi_wr)
   );

   // Previous-sample registers for MCU_WR and SYS_TIME_UPDATE_OK edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mcu_wr_q <= 1'b0;
         r_sys_q    <= 1'b0;
      end else begin
         r_mcu_wr_q <= bus.MCU_WR;
         r_sys_q    <= bus.SYS_TIME_UPDATE_OK;
      end
   end

   // One-entry MCU buffer: fill on edge when empty, free when its write enters GAP.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mcu_full <= 1'b0;
         r_mcu_buf  <= '0;
         r_mcu_drop <= 1'b0;
      end else begin
         r_mcu_drop <= w_mcu_edge & r_mcu_full;
         if (w_mcu_edge && !r_mcu_full) begin
            r_mcu_full <= 1'b1;
            r_mcu_buf  <= bus.MCU_CMD;
         end else if (w_gap_enter && r_cur_mcu) begin
            r_mcu_full <= 1'b0;
         end
      end
   end

   // Command output register and source of the write in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cmd_out <= '0;
         r_cur_mcu <= 1'b0;
         r_cur_rep <= 1'b0;
      end else begin
         if (w_grant_mcu) begin
            r_cmd_out <= w_mcu_src;
            r_cur_mcu <= 1'b1;
            r_cur_rep <= 1'b0;
         end else if (w_grant_rep) begin
            r_cmd_out <= w_rep_cmd;
            r_cur_mcu <= 1'b0;
            r_cur_rep <= 1'b1;
         end else if (w_abort) begin
            // an aborted sequence's in-flight write must not advance a later one
            r_cur_rep <= 1'b0;
         end
      end
   end

   // Repeat engine: start/abort, per-entry advance, completion and late-skip.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rep_active    <= 1'b0;
         r_rep_base      <= '0;
         r_rep_period    <= 64'd0;
         r_rep_remaining <= 16'd0;
         r_next_ts       <= 64'd0;
         r_rep_done      <= 1'b0;
         r_err_late      <= 1'b0;
      end else begin
         r_rep_done <= 1'b0;
         r_err_late <= 1'b0;
         if (w_abort) begin
            r_rep_active <= 1'b0;
         end else if (w_start) begin
            r_rep_base      <= bus.REP_CMD;
            r_rep_period    <= bus.REP_PERIOD;
            r_rep_remaining <= bus.REP_COUNT;
            r_next_ts       <= bus.REP_CMD.TIME_START;
            r_rep_active    <= (bus.REP_COUNT != 16'd0);
            r_rep_done      <= (bus.REP_COUNT == 16'd0);
         end else if (w_done) begin
            r_rep_active <= 1'b0;
            r_rep_done   <= 1'b1;
         end else if (w_skip) begin
            r_next_ts       <= r_next_ts + r_rep_period;
            r_rep_remaining <= r_rep_remaining - 16'd1;
            r_err_late      <= 1'b1;
         end else if (w_gap_enter && r_cur_rep && r_rep_active) begin
            r_next_ts       <= r_next_ts + r_rep_period;
            r_rep_remaining <= r_rep_remaining - 16'd1;
         end
      end
   end

   assign w_cmd_out_bits = r_cmd_out;
   assign bus.CMD_OUT    = w_cmd_out_bits;
   assign bus.SPI_WR     = w_spi_wr;
   assign bus.MCU_BUSY   = r_mcu_full;
   assign bus.MCU_DROP   = r_mcu_drop;
   assign bus.REP_ACTIVE = r_rep_active;
   assign bus.REP_DONE   = r_rep_done;
   assign bus.ERR_LATE   = r_err_late;

endmodule

// File: tb/tb_rt_cmd_scheduler.sv
// tb_rt_cmd_scheduler: directed bench with a scoreboard of expected writes.
// Each SPI_WR rising edge pops one expected command and compares CMD_OUT.
module tb_rt_cmd_scheduler;
   import rt_cmd_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   rt_cmd_scheduler_if bif();

   rt_cmd_scheduler #(
      .WR_PULSE_LEN (5),
      .WR_GAP       (4),
      .LEAD         (64)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   rise_cnt = 0;
   int   done_cnt = 0;
   int   drop_cnt = 0;
   int   late_cnt = 0;
   int   wr_width = 0;
   int   last_done = 0;
   logic prev_spi = 1'b0;
   int   rises[$];
   cmd_t exp_q[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_cmd(input string tag, input cmd_t obs, input cmd_t exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic cmd_t mk_cmd(input logic [63:0] ts, input logic [15:0] tag);
      cmd_t c;
      c.FREQ         = {32'h0000_0000, tag} ^ 48'h1234_5678_9ABC;
      c.FREQ_STEP    = 48'h0000_0000_0100 + {32'h0000_0000, tag};
      c.FREQ_RATE    = {16'h00A5, tag};
      c.TIME_START   = ts;
      c.N_impuls     = tag ^ 16'h0F0F;
      c.TYPE_impulse = tag[1:0];
      c.Interval_Ti  = {tag, 16'h1111};
      c.Interval_Tp  = {16'h2222, tag};
      c.Tblank1      = {tag, tag};
      c.Tblank2      = 32'hDEAD_0000 | {16'h0000, tag};
      return c;
   endfunction

   // One clock: sample at negedge, score writes, measure widths, count pulses.
   task automatic tick();
      bit   have;
      cmd_t e;
      @(negedge clk);
      cyc++;
      if (bif.SPI_WR && !prev_spi) begin
         rise_cnt++;
         rises.push_back(cyc);
         wr_width = 1;
         have = (exp_q.size() != 0);
         chk("sb_has_entry", 64'(have), 64'd1);
         if (have) begin
            e = exp_q.pop_front();
            chk_cmd("cmd_out", bif.CMD_OUT, e);
         end
      end else if (bif.SPI_WR) begin
         wr_width++;
      end else if (prev_spi) begin
         chk("wr_width", 64'(wr_width), 64'd5);
      end
      prev_spi = bif.SPI_WR;
      if (bif.REP_DONE) begin
         done_cnt++;
         last_done = cyc;
      end
      if (bif.MCU_DROP) drop_cnt++;
      if (bif.ERR_LATE) late_cnt++;
   endtask

   int   t0, n0, d0, dr0, l0;
   cmd_t m, base;

   initial begin
      rst = 1'b1;
      bif.TIME = 64'd0;
      bif.SYS_TIME_UPDATE_OK = 1'b0;
      bif.MCU_CMD = '0;
      bif.MCU_WR = 1'b0;
      bif.REP_CMD = '0;
      bif.REP_PERIOD = 64'd0;
      bif.REP_COUNT = 16'd0;
      bif.REP_START = 1'b0;
      bif.REP_ABORT = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      chk("reset_flags", 64'({bif.MCU_BUSY, bif.MCU_DROP, bif.REP_ACTIVE, bif.REP_DONE, bif.ERR_LATE, bif.SPI_WR}), 64'd0);
      chk_cmd("reset_cmd_out", bif.CMD_OUT, '0);
      repeat (2) tick();

      // 1: single MCU write
      rises.delete();
      n0 = rise_cnt;
      m = mk_cmd(64'h22C0, 16'h0001);
      bif.MCU_CMD = m;
      bif.MCU_WR = 1'b1;
      exp_q.push_back(m);
      t0 = cyc;
      tick();
      chk("t1_busy_set", 64'(bif.MCU_BUSY), 64'd1);
      tick();
      chk("t1_rise_latency", 64'(rises[0] - t0), 64'd2);
      repeat (3) tick();
      bif.MCU_WR = 1'b0;
      tick();
      chk("t1_busy_in_write", 64'(bif.MCU_BUSY), 64'd1);
      tick();
      chk("t1_busy_clear_gap", 64'(bif.MCU_BUSY), 64'd0);
      repeat (10) tick();
      chk("t1_write_count", 64'(rise_cnt - n0), 64'd1);

      // 2: repeat of 3
      rises.delete();
      n0 = rise_cnt;
      d0 = done_cnt;
      base = mk_cmd(64'h22C0, 16'h0002);
      exp_q.push_back(mk_cmd(64'h22C0, 16'h0002));
      exp_q.push_back(mk_cmd(64'h92C0, 16'h0002));
      exp_q.push_back(mk_cmd(64'h102C0, 16'h0002));
      bif.REP_CMD = base;
      bif.REP_PERIOD = 64'h7000;
      bif.REP_COUNT = 16'd3;
      bif.REP_START = 1'b1;
      tick();
      bif.REP_START = 1'b0;
      chk("t2_active", 64'(bif.REP_ACTIVE), 64'd1);
      repeat (40) tick();
      chk("t2_write_count", 64'(rise_cnt - n0), 64'd3);
      chk("t2_rise_gap1", 64'(rises[1] - rises[0]), 64'd10);
      chk("t2_rise_gap2", 64'(rises[2] - rises[1]), 64'd10);
      chk("t2_done_count", 64'(done_cnt - d0), 64'd1);
      chk("t2_done_pos", 64'(last_done - rises[2]), 64'd9);
      chk("t2_active_end", 64'(bif.REP_ACTIVE), 64'd0);
      chk("t2_sb_drained", 64'(exp_q.size()), 64'd0);

      // 3: MCU edge interleaved into a repeat, plus a dropped edge
      rises.delete();
      n0 = rise_cnt;
      d0 = done_cnt;
      dr0 = drop_cnt;
      base = mk_cmd(64'h22C0, 16'h0003);
      exp_q.push_back(mk_cmd(64'h22C0, 16'h0003));
      exp_q.push_back(mk_cmd(64'h92C0, 16'h0003));
      bif.REP_CMD = base;
      bif.REP_START = 1'b1;
      tick();
      bif.REP_START = 1'b0;
      repeat (13) tick();
      m = mk_cmd(64'h5555, 16'h0033);
      bif.MCU_CMD = m;
      bif.MCU_WR = 1'b1;
      exp_q.push_back(m);
      exp_q.push_back(mk_cmd(64'h102C0, 16'h0003));
      tick();
      chk("t3_busy", 64'(bif.MCU_BUSY), 64'd1);
      tick();
      bif.MCU_WR = 1'b0;
      bif.MCU_CMD = mk_cmd(64'h6666, 16'h0044);
      tick();
      bif.MCU_WR = 1'b1;
      tick();
      chk("t3_drop_pulse", 64'(bif.MCU_DROP), 64'd1);
      bif.MCU_WR = 1'b0;
      repeat (45) tick();
      chk("t3_write_count", 64'(rise_cnt - n0), 64'd4);
      chk("t3_drop_count", 64'(drop_cnt - dr0), 64'd1);
      chk("t3_done_count", 64'(done_cnt - d0), 64'd1);
      chk("t3_sb_drained", 64'(exp_q.size()), 64'd0);

      // 4: zero count, then start together with abort
      n0 = rise_cnt;
      d0 = done_cnt;
      bif.REP_CMD = mk_cmd(64'h1000, 16'h0004);
      bif.REP_COUNT = 16'd0;
      bif.REP_START = 1'b1;
      tick();
      bif.REP_START = 1'b0;
      chk("t4_done_next", 64'(bif.REP_DONE), 64'd1);
      chk("t4_inactive", 64'(bif.REP_ACTIVE), 64'd0);
      repeat (15) tick();
      bif.REP_COUNT = 16'd2;
      bif.REP_START = 1'b1;
      bif.REP_ABORT = 1'b1;
      tick();
      bif.REP_START = 1'b0;
      bif.REP_ABORT = 1'b0;
      chk("t4_abort_wins", 64'(bif.REP_ACTIVE), 64'd0);
      repeat (20) tick();
      chk("t4_no_writes", 64'(rise_cnt - n0), 64'd0);
      chk("t4_done_count", 64'(done_cnt - d0), 64'd1);

      // 5: system time update aborts during the first write
      n0 = rise_cnt;
      d0 = done_cnt;
      bif.REP_CMD = mk_cmd(64'h22C0, 16'h0005);
      bif.REP_COUNT = 16'd3;
      exp_q.push_back(mk_cmd(64'h22C0, 16'h0005));
      bif.REP_START = 1'b1;
      tick();
      bif.REP_START = 1'b0;
      repeat (3) tick();
      bif.SYS_TIME_UPDATE_OK = 1'b1;
      tick();
      chk("t5_inactive", 64'(bif.REP_ACTIVE), 64'd0);
      chk("t5_write_continues", 64'(bif.SPI_WR), 64'd1);
      repeat (5) tick();
      bif.SYS_TIME_UPDATE_OK = 1'b0;
      repeat (35) tick();
      chk("t5_write_count", 64'(rise_cnt - n0), 64'd1);
      chk("t5_no_done", 64'(done_cnt - d0), 64'd0);
      chk("t5_sb_drained", 64'(exp_q.size()), 64'd0);

      // 6: late-entry handling
      n0 = rise_cnt;
      d0 = done_cnt;
      l0 = late_cnt;
      bif.TIME = 64'h3000;
      bif.REP_CMD = mk_cmd(64'h22C0, 16'h0006);
      bif.REP_PERIOD = 64'h7000;
      bif.REP_COUNT = 16'd2;
`ifdef RT_LATE_SKIP_EN
      exp_q.push_back(mk_cmd(64'h92C0, 16'h0006));
`else
      exp_q.push_back(mk_cmd(64'h22C0, 16'h0006));
      exp_q.push_back(mk_cmd(64'h92C0, 16'h0006));
`endif
      bif.REP_START = 1'b1;
      tick();
      bif.REP_START = 1'b0;
      repeat (35) tick();
`ifdef RT_LATE_SKIP_EN
      chk("t6_late_count", 64'(late_cnt - l0), 64'd1);
      chk("t6_write_count", 64'(rise_cnt - n0), 64'd1);
`else
      chk("t6_late_count", 64'(late_cnt - l0), 64'd0);
      chk("t6_write_count", 64'(rise_cnt - n0), 64'd2);
`endif
      chk("t6_done_count", 64'(done_cnt - d0), 64'd1);
      chk("t6_sb_drained", 64'(exp_q.size()), 64'd0);

      // 7: reset in the middle of a write drops SPI_WR at once
      m = mk_cmd(64'h7777, 16'h0007);
      bif.MCU_CMD = m;
      bif.MCU_WR = 1'b1;
      exp_q.push_back(m);
      tick();
      bif.MCU_WR = 1'b0;
      tick();
      chk("t7_in_write", 64'(bif.SPI_WR), 64'd1);
      rst = 1'b1;
      #1;
      chk("t7_reset_spi_wr", 64'(bif.SPI_WR), 64'd0);
      chk("t7_reset_busy", 64'(bif.MCU_BUSY), 64'd0);
      prev_spi = 1'b0;
      tick();
      rst = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
